// File: rtl/fib_and_mem_if.sv
// rtl/fib_and_mem_if.sv - Term-index / result bundle for the Fibonacci generator and store
interface fib_and_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] n;
    logic [DATA_W-1:0] value;
    logic              ready;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] dataout;

    // Driver of the term index and observer of the results.
    modport master (
        output n,
        input  value, ready, counter, address, dataout
    );

    // Generator/store side.
    modport slave (
        input  n,
        output value, ready, counter, address, dataout
    );
endinterface

// File: rtl/fib_and_mem.sv
// rtl/fib_and_mem.sv - Sequential Fibonacci generator with result memory (FIB_SAT_EN: saturating add)
module fib_and_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic          clk,
    input  logic          rst,
    fib_and_mem_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              load;
    logic              step;
    logic              last;

    logic [ADDR_W-1:0] n_reg;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] value;
    logic              ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] b_next;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef FIB_SAT_EN
    logic [DATA_W:0]   sum_wide;

    // Clamp to all-ones on carry out; a saturated operand keeps every later term saturated.
    always_comb begin
        sum_wide = {1'b0, a} + {1'b0, b};
        b_next   = sum_wide[DATA_W] ? {DATA_W{1'b1}} : sum_wide[DATA_W-1:0];
    end
`else
    // Plain modulo-2^DATA_W addition.
    always_comb begin
        b_next = a + b;
    end
`endif

    // State register; reset drops straight back to IDLE without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one load edge, then one term per edge until index n_reg is written.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = (counter == n_reg);
        case (state)
            IDLE: begin
                load       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch n on the load edge, then advance the (a, b) pair each RUN edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_reg   <= '0;
            counter <= '0;
            address <= '0;
            value   <= '0;
            ready   <= 1'b0;
            a       <= '0;
            b       <= DATA_W'(1);
        end else begin
            if (load) begin
                n_reg <= bus.n;
            end
            if (step) begin
                value   <= a;
                address <= counter;
                a       <= b;
                b       <= b_next;
                if (last) begin
                    ready <= 1'b1;
                end else begin
                    counter <= counter + ADDR_W'(1);
                end
            end
        end
    end

    // Result store; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (step) begin
            mem[counter] <= a;
        end
    end

    // Read-back of the most recently written word, blanked before the first term exists.
    always_comb begin
        bus.dataout = (state == IDLE) ? '0 : mem[address];
    end

    assign bus.value   = value;
    assign bus.ready   = ready;
    assign bus.counter = counter;
    assign bus.address = address;

endmodule

// File: tb/tb_fib_and_mem.sv
// tb/tb_fib_and_mem.sv - Self-checking bench for fib_and_mem (FIB_SAT_EN selects saturating expectations)
module tb_fib_and_mem;

    logic clk;
    logic rst;

    fib_and_mem_if #(.DATA_W(32), .ADDR_W(6)) bus ();

    fib_and_mem #(.DATA_W(32), .ADDR_W(6), .DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        int          n_late;
        logic [31:0] final_val;
    } vec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } sb_t;

    vec_t vecs [7];
    sb_t  sbq [$];
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},   64'(bus.ready),   64'd0);
        chk({tag, "_counter"}, 64'(bus.counter), 64'd0);
        chk({tag, "_address"}, 64'(bus.address), 64'd0);
        chk({tag, "_value"},   64'(bus.value),   64'd0);
        chk({tag, "_dataout"}, 64'(bus.dataout), 64'd0);
    endtask

    task automatic run_case(input int nn, input int n_late, input logic [31:0] final_val);
        logic [63:0] fa;
        logic [63:0] fb;
        logic [63:0] t;
        sb_t         e;
        int          ni;
        int          nl;
        ni = nn;
        nl = n_late;
        rst = 1'b0;
        bus.n = ni[5:0];
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_dataout", 64'(bus.dataout), 64'd0);

        // Expected terms: exact Fibonacci, reduced to 32 bits by wrap or clamp.
        sbq.delete();
        fa = 64'd0;
        fb = 64'd1;
        for (int k = 0; k <= ni; k++) begin
            e.addr = 6'(k);
`ifdef FIB_SAT_EN
            e.data = (fa > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : fa[31:0];
`else
            e.data = fa[31:0];
`endif
            sbq.push_back(e);
            t  = fa + fb;
            fa = fb;
            fb = t;
        end

        for (int ed = 1; ed <= ni + 4; ed++) begin
            @(posedge clk);
            #1;
            if (ed == 1) begin
                bus.n = nl[5:0];
                chk("load_ready",   64'(bus.ready),   64'd0);
                chk("load_counter", 64'(bus.counter), 64'd0);
            end else if (ed <= ni + 2) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("run_value",   64'(bus.value),   64'(e.data));
                    chk("run_address", 64'(bus.address), 64'(e.addr));
                    chk("run_dataout", 64'(bus.dataout), 64'(e.data));
                    chk("run_counter", 64'(bus.counter),
                        64'((int'(e.addr) < ni) ? int'(e.addr) + 1 : ni));
                end
                chk("run_ready", 64'(bus.ready), 64'((ed == ni + 2) ? 1 : 0));
            end else begin
                chk("hold_ready",   64'(bus.ready),   64'd1);
                chk("hold_counter", 64'(bus.counter), 64'(ni));
                chk("hold_address", 64'(bus.address), 64'(ni));
                chk("hold_value",   64'(bus.value),   64'(final_val));
            end
        end
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        chk("final_value",   64'(bus.value),   64'(final_val));
        chk("final_dataout", 64'(bus.dataout), 64'(final_val));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.n  = '0;

        vecs[0] = '{n: 5,  n_late: 10, final_val: 32'd5};
        vecs[1] = '{n: 0,  n_late: 0,  final_val: 32'd0};
        vecs[2] = '{n: 1,  n_late: 1,  final_val: 32'd1};
        vecs[3] = '{n: 2,  n_late: 63, final_val: 32'd1};
        vecs[4] = '{n: 47, n_late: 47, final_val: 32'd2971215073};
`ifdef FIB_SAT_EN
        vecs[5] = '{n: 48, n_late: 48, final_val: 32'hFFFF_FFFF};
        vecs[6] = '{n: 63, n_late: 0,  final_val: 32'hFFFF_FFFF};
`else
        vecs[5] = '{n: 48, n_late: 48, final_val: 32'd512559680};
        vecs[6] = '{n: 63, n_late: 0,  final_val: 32'd3350226146};
`endif

        #1;
        chk_reset_outputs("por");

        for (int i = 0; i < 7; i++) begin
            run_case(vecs[i].n, vecs[i].n_late, vecs[i].final_val);
        end

        // Abort mid-RUN: reset must clear outputs without waiting for a clock edge.
        rst   = 1'b0;
        bus.n = 6'd10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        begin
            int waited;
            waited = 0;
            while (bus.counter != 6'd3 && waited < 20) begin
                @(posedge clk);
                #1;
                waited++;
            end
            chk("abort_reach_counter3", 64'(bus.counter), 64'd3);
        end
        chk("abort_pre_ready", 64'(bus.ready), 64'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("abort");
        run_case(2, 2, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_and_mem.md
# fib_and_mem

Sequential Fibonacci generator with an on-chip result store. After reset it latches a term index `n`, computes F(0)…F(n) one term per clock, and writes each term into a 64-entry word memory at the term's index. It asserts `ready` when F(n) is done and holds all results until the next reset. It is a self-contained compute/store leaf with a read-back port for inspection.

## Interface
Parameters:
- `DATA_W`, default 32: width of a Fibonacci term and of each memory word.
- `ADDR_W`, default 6: width of `n`, `counter` and `address`.
- `DEPTH`, default 64 (2^ADDR_W): number of memory words.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `n`, input, ADDR_W: index of the last term to compute (0..63).
- `value`, output, DATA_W: term most recently written.
- `ready`, output, 1: computation complete.
- `counter`, output, ADDR_W: current term index.
- `address`, output, ADDR_W: memory location most recently written.
- `dataout`, output, DATA_W: memory read-back at `address`.

## Operation
- State machine with three states: IDLE, RUN, DONE.
- **Reset (`rst`=0), asynchronous:**
  - state=IDLE, counter=0, address=0, value=0, ready=0.
  - Internal registers: a=0 (F(k)), b=1 (F(k+1)), n_reg=0.
  - Memory contents are not reset.
- **IDLE:**
  - First rising edge with `rst`=1: n_reg<=n, then go to RUN.
  - `n` is sampled only at this edge; later changes to `n` are ignored until the next reset.
- **RUN**, each rising edge:
  - mem[counter]<=a, value<=a, address<=counter, a<=b, b<=a+b.
  - If counter==n_reg: ready<=1 and go to DONE; counter stays at n_reg.
  - Otherwise counter<=counter+1.
- **DONE:**
  - All registers and memory hold.
  - `ready` stays 1 until reset.
- **dataout:**
  - Combinational read of mem[address].
  - Forced to 0 while state=IDLE.
  - After the first RUN edge, dataout equals value.
- **Arithmetic:** a+b is unsigned DATA_W-bit and wraps modulo 2^32 by default; see Configuration.
- **Boundaries:**
  - n=0: exactly one write, mem[0]=0.
  - n=63: the counter never wraps.
  - Reset asserted mid-RUN aborts immediately. Memory keeps the words already written; the next run overwrites them.

## Timing
- Latency: `ready` rises at the (n+2)th rising edge after `rst` deasserts (1 load edge + n+1 compute edges).
- `ready`, `value`, `counter` and `address` are registered outputs. `dataout` follows `address` combinationally.
- F(k) is visible on `value` after the edge that writes mem[k].
- Reset takes effect asynchronously, with no clock required.

## Configuration
- Macro: `FIB_SAT_EN`.
- Defined: the a+b update saturates at 2^DATA_W−1 (32'hFFFF_FFFF) instead of wrapping. Once saturated, subsequent terms stay saturated.
- Undefined (default): modulo-2^DATA_W wrap.

## Test plan
- n=5, rst low for 2 edges then high: `ready` rises on the 7th edge; then value=5, counter=5, address=5, dataout=5; mem[0..5]=0,1,1,2,3,5.
- n=0: `ready` rises on the 2nd edge with value=0, counter=0, address=0, dataout=0.
- n=47: at ready, value=2971215073 and mem[46]=1836311903.
- n=48: wrap build gives value=512559680 (4807526976 mod 2^32); `FIB_SAT_EN` build gives 32'hFFFF_FFFF.
- Change `n` from 5 to 10 after the load edge: completion still at index 5 on the 7th edge.
- Assert rst at counter=3 in RUN: all outputs go to their reset values immediately. After release with n=2, `ready` rises on the 4th edge with value=1.
